vga_scan_driver: RTL and testbench

- Drives the pixel-coordinate interface that overlay generators consume: free-running 640x480@60 scan counters producing x, y and active.
- Consumes each overlay's combinational draw/rgb response and emits registered hsync, vsync and rgb to the VGA pins.
- Sits at the top of the video path; the overlay generators hang combinationally between its coordinate outputs and its pixel inputs.

---
 rtl/vga_scan_driver.sv | 118 +++++++++++
 tb/tb_vga_scan_driver.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_driver.sv
// 640x480@60 scan driver: free-running x/y counters, sync decode, registered sync/pixel output.
// Define VGA_FRAME_COUNTER_EN to build the 8-bit frame counter; otherwise frame_cnt is tied to 0.
module vga_scan_driver #(
  parameter int H_ACTIVE         = 640,
  parameter int H_FRONT          = 16,
  parameter int H_SYNC           = 96,
  parameter int H_BACK           = 48,
  parameter int V_ACTIVE         = 480,
  parameter int V_FRONT          = 10,
  parameter int V_SYNC           = 2,
  parameter int V_BACK           = 33,
  parameter int SYNC_ACTIVE_HIGH = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       line_start,
  output logic       frame_start,
  input  logic       ov_draw,
  input  logic [5:0] ov_rgb,
  input  logic [5:0] bg_rgb,
  output logic       hsync,
  output logic       vsync,
  output logic [5:0] rgb_out,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic       SYNC_ON  = (SYNC_ACTIVE_HIGH != 0);
  localparam logic       SYNC_OFF = ~SYNC_ON;

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       x_wrap;
  logic       hs_win, vs_win;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic [5:0] rgb_q, rgb_d;

  assign x           = x_q;
  assign y           = y_q;
  assign active      = (x_q < H_ACT) && (y_q < V_ACT);
  assign line_start  = (x_q == 10'd0);
  assign frame_start = (x_q == 10'd0) && (y_q == 10'd0);
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign rgb_out     = rgb_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    x_d     = x_q + 10'd1;
    y_d     = y_q;
    x_wrap  = (x_q == H_LAST);
    hs_win  = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
    vs_win  = (y_q >= VS_FIRST) && (y_q <= VS_LAST);
    hsync_d = hs_win ? SYNC_ON : SYNC_OFF;
    vsync_d = vs_win ? SYNC_ON : SYNC_OFF;
    rgb_d   = 6'b000000;

    if (x_wrap) begin
      x_d = 10'd0;
      y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
    end

    if (active) begin
      rgb_d = ov_draw ? ov_rgb : bg_rgb;
    end
  end

  // Sync and colour share this one stage so they leave the block mutually aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      hsync_q <= SYNC_OFF;
      vsync_q <= SYNC_OFF;
      rgb_q   <= 6'b000000;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

`ifdef VGA_FRAME_COUNTER_EN
  logic       frame_wrap;
  logic [7:0] frame_cnt_q;

  assign frame_wrap = x_wrap && (y_q == V_LAST);
  assign frame_cnt  = frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= 8'h00;
    end else if (frame_wrap) begin
      frame_cnt_q <= frame_cnt_q + 8'h01;
    end
  end
`else
  assign frame_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_vga_scan_driver.sv
// Directed bench: full-size instance for reset, line timing, colour mux and mid-frame reset;
// a reduced-timing instance (16x12 totals) for frame timing, vertical blanking and frame_cnt.
module tb_vga_scan_driver;

`ifdef VGA_FRAME_COUNTER_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  // Reduced instance: hsync x in [10,12], vsync y in [8,9], 192 clk per frame.
  localparam int S_HTOT  = 16;
  localparam int S_VTOT  = 12;
  localparam int S_FRAME = S_HTOT * S_VTOT;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ov_draw;
  logic [5:0] ov_rgb, bg_rgb;

  logic [9:0] x, y;
  logic       active, line_start, frame_start, hsync, vsync;
  logic [5:0] rgb_out;
  logic [7:0] frame_cnt;

  logic [9:0] s_x, s_y;
  logic       s_active, s_line_start, s_frame_start, s_hsync, s_vsync;
  logic [5:0] s_rgb_out;
  logic [7:0] s_frame_cnt;

  int checks = 0;
  int errors = 0;

  always #20 clk = ~clk;

  vga_scan_driver dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .active(active),
    .line_start(line_start), .frame_start(frame_start),
    .ov_draw(ov_draw), .ov_rgb(ov_rgb), .bg_rgb(bg_rgb),
    .hsync(hsync), .vsync(vsync), .rgb_out(rgb_out), .frame_cnt(frame_cnt)
  );

  vga_scan_driver #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
    .SYNC_ACTIVE_HIGH(0)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .x(s_x), .y(s_y), .active(s_active),
    .line_start(s_line_start), .frame_start(s_frame_start),
    .ov_draw(ov_draw), .ov_rgb(ov_rgb), .bg_rgb(bg_rgb),
    .hsync(s_hsync), .vsync(s_vsync), .rgb_out(s_rgb_out), .frame_cnt(s_frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] fc_exp(input int frames);
    return FC_EN ? 8'(frames % 256) : 8'h00;
  endfunction

  initial begin
    int low_cnt, first_low, fs_cnt, on_cnt, off_cnt;

    rst_n   = 1'b0;
    ov_draw = 1'b0;
    ov_rgb  = 6'b000000;
    bg_rgb  = 6'b000000;

    // Reset
    repeat (5) @(negedge clk);
    check("rst_x", x, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    rst_n = 1'b1;
    #1;
    check("rel_x", x, 0);
    check("rel_y", y, 0);
    check("rel_active", active, 1);
    check("rel_line_start", line_start, 1);
    check("rel_frame_start", frame_start, 1);
    check("rel_hsync", hsync, 1);
    check("rel_vsync", vsync, 1);
    check("rel_rgb", rgb_out, 0);
    @(negedge clk);
    check("c1_x", x, 1);
    check("c1_frame_start", frame_start, 0);
    check("c1_line_start", line_start, 0);

    // Line timing: cycles 2..800 after release
    low_cnt   = 0;
    first_low = 0;
    for (int c = 2; c <= 800; c++) begin
      @(negedge clk);
      if (hsync == 1'b0) begin
        low_cnt++;
        if (first_low == 0) first_low = c;
      end
    end
    check("hsync_low_cycles", low_cnt, 96);
    check("hsync_first_low", first_low, 657);
    check("line_wrap_x", x, 0);
    check("line_wrap_y", y, 1);
    check("line_wrap_line_start", line_start, 1);
    check("line_wrap_frame_start", frame_start, 0);

    // Colour mux at x=100 on an active line
    ov_draw = 1'b1;
    ov_rgb  = 6'b110110;
    bg_rgb  = 6'b000011;
    repeat (100) @(negedge clk);
    check("mux_x", x, 100);
    check("mux_active", active, 1);
    @(negedge clk);
    check("mux_ov", rgb_out, 6'b110110);
    ov_draw = 1'b0;
    @(negedge clk);
    check("mux_bg", rgb_out, 6'b000011);

    // Horizontal blanking at x=700
    ov_draw = 1'b1;
    ov_rgb  = 6'b111111;
    repeat (598) @(negedge clk);
    check("blank_x", x, 700);
    check("blank_active", active, 0);
    @(negedge clk);
    check("blank_h_rgb", rgb_out, 0);
    check("blank_hsync", hsync, 0);

    // Mid-frame reset with a lit pixel in the output register
    repeat (399) @(negedge clk);
    check("pre_rst_x", x, 300);
    check("pre_rst_y", y, 2);
    check("pre_rst_rgb", rgb_out, 6'b111111);
    #5 rst_n = 1'b0;
    #1;
    check("mid_rst_x", x, 0);
    check("mid_rst_y", y, 0);
    check("mid_rst_frame_start", frame_start, 1);
    check("mid_rst_hsync", hsync, 1);
    check("mid_rst_vsync", vsync, 1);
    check("mid_rst_rgb", rgb_out, 0);
    check("mid_rst_s_x", s_x, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // One full frame on the reduced instance
    low_cnt   = 0;
    first_low = 0;
    fs_cnt    = 0;
    on_cnt    = 0;
    off_cnt   = 0;
    for (int c = 1; c <= S_FRAME; c++) begin
      @(negedge clk);
      if (s_vsync == 1'b0) begin
        low_cnt++;
        if (first_low == 0) first_low = c;
      end
      if (s_frame_start) fs_cnt++;
      if (s_rgb_out == 6'b111111) on_cnt++;
      else if (s_rgb_out == 6'b000000) off_cnt++;
      if (c == S_FRAME - 1) begin
        check("s_pre_wrap_x", s_x, S_HTOT - 1);
        check("s_pre_wrap_y", s_y, S_VTOT - 1);
      end
    end
    check("s_vsync_low_cycles", low_cnt, 2 * S_HTOT);
    check("s_vsync_first_low", first_low, 8 * S_HTOT + 1);
    check("s_frame_start_pulses", fs_cnt, 1);
    check("s_lit_pixels", on_cnt, 48);
    check("s_blank_pixels", off_cnt, S_FRAME - 48);
    check("s_wrap_x", s_x, 0);
    check("s_wrap_y", s_y, 0);
    check("s_wrap_frame_start", s_frame_start, 1);
    check("s_frame_cnt_1", s_frame_cnt, fc_exp(1));
    @(negedge clk);
    check("s_frame_start_one_cycle", s_frame_start, 0);

    // Frame counter over 256 frames
    for (int f = 2; f <= 256; f++) begin
      repeat (S_FRAME) @(negedge clk);
      check("s_frame_pos_x", s_x, 1);
      check("s_frame_cnt", s_frame_cnt, fc_exp(f));
    end
    check("big_frame_cnt", frame_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
